clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Run/stop controller and reprogramming sequencer for the shared clock-divider datapath. It produces the divided square wave and a one-cycle tick enable for downstream serial/audio logic. An asynchronous run request is synchronized internally with two flops. Divisor changes are applied glitch-free, only at period boundaries, and each accepted change is acknowledged.

Parameters:
WIDTH, 8, width of divisor and period counter
DEFAULT_DIV, 8, divisor loaded at reset (must be 1..2^WIDTH-1)

Ports:
clk  in  1  system clock, all logic posedge
reset  in  1  synchronous, active-high reset
run_async  in  1  asynchronous run request; 2-FF synchronized internally to run_sync
div_in  in  WIDTH  new divisor N
div_load  in  1  one-cycle pulse: request divisor change to div_in
div_ack  out  1  one-cycle pulse: requested divisor now in effect
div_err  out  1  one-cycle pulse: load rejected (div_in==0)
tick  out  1  one-cycle enable at last cycle of each period
div_out  out  1  divided square wave
busy  out  1  high in RUN or DRAIN
cur_div  out  WIDTH  divisor currently in effect

Behaviour:
- Reset: state=IDLE; counter=0; pending cleared; cur_div=DEFAULT_DIV; tick, div_out, busy, div_ack, div_err all 0; sync flops 0.
- Synchronizer: run_sync is run_async delayed by two clk flops; no other logic samples run_async.
- Counter: runs 0..cur_div-1 and wraps to 0. Terminal count (TC) = busy && counter==cur_div-1.
- tick = TC, combinational from registered state/counter.
- div_out = busy && counter >= cur_div/2 (floor). For N=8 it is low for counts 0-3 and high for 4-7. For N=1 div_out is held 1 and tick fires every cycle while busy.
- States:
  - IDLE: counter held 0; div_out=0, tick=0. Goes to RUN when run_sync=1; the first RUN cycle has counter=0.
  - RUN: counter advances each cycle. Goes to DRAIN when run_sync=0; the counter keeps advancing.
  - DRAIN: finishes the current period. At the TC edge it goes to IDLE with counter=0; the final tick is still issued. If run_sync=1 again before TC, it returns to RUN with no counter disturbance.
- Latency: first tick occurs N cycles after entering RUN, i.e. about N+2 cycles after run_async rises.
- Load handshake:
  - div_load with div_in==0: ignored; div_err=1 on the next cycle.
  - Valid load in IDLE: cur_div=div_in at the next edge; div_ack=1 the cycle after.
  - Valid load while busy: div_in captured into pending. It is applied at the next TC edge, together with counter wrap to 0. div_ack=1 the cycle after that edge.
  - Load coincident with TC: div_in is applied at that same edge (bypasses pending), then ack.
  - Second load while a load is pending: overwrites pending (last write wins). Only one ack is issued, when the value is applied.
  - Pending at DRAIN→IDLE: applied at that TC edge.
- The period in progress always completes with the old divisor; no short or long pulse appears on div_out.
- Reset mid-operation: immediate return to reset values on the next edge; pending is discarded and no ack is issued.
- Counter arithmetic: WIDTH bits, compared against cur_div-1. cur_div is never 0.

Test Plan:
- Reset, run_async=1, default N=8 → busy after 2 sync cycles; div_out 4 low/4 high; tick every 8 cycles; first tick 8 cycles after RUN entry.
- Running N=8, div_load with div_in=5 at counter=2 → old period completes (tick at counter 7); cur_div=5 at wrap; div_ack the next cycle; then period 5 with div_out low 2/high 3.
- div_load div_in=0 → div_err pulse the next cycle; cur_div unchanged; no ack.
- run_async dropped mid-period at counter=3 (N=8) → ticks continue through counter 7, then IDLE with busy=0, div_out=0. Repeat with run_async re-raised before TC → no gap in ticks.
- Idle, N=1 load then run → div_ack after 1 cycle; tick=1 and div_out=1 every busy cycle.
- Two loads (6 then 3) within one period, then reset asserted in the middle of a later period → only cur_div=3 applied with a single ack. Reset restores cur_div=8 and all outputs to 0.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// ============================================================================
// Module : clk_div_ctrl_if
// Brief  : Run-request, divisor-load and divided-clock signals of clk_div_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface clk_div_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             run_async;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             tick;
  logic             div_out;
  logic             busy;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output run_async, div_in, div_load,
    input  div_ack, div_err, tick, div_out, busy, cur_div
  );

  modport slave (
    input  run_async, div_in, div_load,
    output div_ack, div_err, tick, div_out, busy, cur_div
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module : clk_div_ctrl
// Brief  : Run/stop controller and glitch-free divisor sequencer for the
//          shared clock divider; emits square wave, tick and load handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] cur_div_q,  cur_div_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q,     pend_d;
  logic             ack_q,      ack_d;
  logic             err_q,      err_d;
  logic             sync1_q,    sync2_q;

  logic w_run_sync;
  logic w_busy;
  logic w_tc;
  logic w_load_ok;

  assign w_run_sync = sync2_q;
  assign w_busy     = (state_q != S_IDLE);
  assign w_tc       = w_busy && (cnt_q == (cur_div_q - C_ONE));
  assign w_load_ok  = bus.div_load && (bus.div_in != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= WIDTH'(DEFAULT_DIV);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      sync1_q    <= bus.run_async;
      sync2_q    <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    err_d      = bus.div_load && (bus.div_in == '0);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_run_sync) state_d = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        cnt_d = w_tc ? '0 : cnt_q + C_ONE;
        // A raised run request keeps the divider going even across TC.
        if (w_run_sync)  state_d = S_RUN;
        else if (w_tc)   state_d = S_IDLE;
        else             state_d = S_DRAIN;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // New divisors only take effect at a period boundary or while stopped.
    if (w_load_ok && (!w_busy || w_tc)) begin
      cur_div_d = bus.div_in;
      ack_d     = 1'b1;
      pend_d    = 1'b0;
    end else if (w_load_ok) begin
      pend_d     = 1'b1;
      pend_val_d = bus.div_in;
    end else if (w_tc && pend_q) begin
      cur_div_d = pend_val_q;
      ack_d     = 1'b1;
      pend_d    = 1'b0;
    end
  end

  assign bus.tick    = w_tc;
  assign bus.div_out = w_busy && (cnt_q >= (cur_div_q >> 1));
  assign bus.busy    = w_busy;
  assign bus.cur_div = cur_div_q;
  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module : tb_clk_div_ctrl
// Brief  : Self-checking bench for clk_div_ctrl: vector table, directed
//          corner sequences and randomized traffic against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.WIDTH(W)) bus();

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen = 0;
  int tick_seen = 0;

  // Reference model: run history, active flag, phase in period, divisor.
  bit m_h0, m_h1, m_act, m_pend, m_ack, m_err;
  int m_n = 8, m_ph, m_pval;

  typedef struct {
    bit r; bit ra; bit ld; int d;
    bit busy; bit tick; bit dout; bit ack; bit err; int cur;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ra, input bit ld, input int d);
    bit was, tc;
    if (r) begin
      m_h0 = 0; m_h1 = 0; m_act = 0; m_pend = 0; m_ack = 0; m_err = 0;
      m_n = 8; m_ph = 0; m_pval = 0;
      return;
    end
    was   = m_act;
    tc    = m_act && (m_ph == m_n - 1);
    m_err = ld && (d == 0);
    m_ack = 0;
    if (was) begin
      m_ph  = tc ? 0 : m_ph + 1;
      m_act = m_h1 || !tc;
    end else if (m_h1) begin
      m_act = 1;
      m_ph  = 0;
    end
    if (ld && d != 0) begin
      if (!was || tc) begin m_n = d; m_ack = 1; m_pend = 0; end
      else begin m_pend = 1; m_pval = d; end
    end else if (tc && m_pend) begin
      m_n = m_pval; m_ack = 1; m_pend = 0;
    end
    m_h1 = m_h0;
    m_h0 = ra;
  endtask

  task automatic drive(input bit r, input bit ra, input bit ld, input int d);
    @(negedge clk);
    reset = r; bus.run_async = ra; bus.div_load = ld; bus.div_in = W'(d);
    @(posedge clk);
    model_step(r, ra, ld, d);
    #1;
    if (bus.div_ack === 1'b1) ack_seen++;
    if (bus.tick === 1'b1) tick_seen++;
  endtask

  task automatic check_model();
    chk("busy",    16'(bus.busy),    16'(m_act));
    chk("tick",    16'(bus.tick),    16'(m_act && m_ph == m_n - 1));
    chk("div_out", 16'(bus.div_out), 16'(m_act && m_ph >= m_n / 2));
    chk("div_ack", 16'(bus.div_ack), 16'(m_ack));
    chk("div_err", 16'(bus.div_err), 16'(m_err));
    chk("cur_div", 16'(bus.cur_div), 16'(m_n));
  endtask

  task automatic step(input bit r, input bit ra, input bit ld, input int d);
    drive(r, ra, ld, d);
    check_model();
  endtask

  initial begin
    bit ra;
    bus.run_async = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;

    //          r ra ld d   busy tick dout ack err cur
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 8};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8};
    tbl[3]  = '{0, 0, 1, 3, 0, 0, 0, 1, 0, 3};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 3};
    tbl[8]  = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 3};
    tbl[9]  = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 3};
    tbl[10] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 3};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 3};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 3};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[14] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 1};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].ra, tbl[i].ld, tbl[i].d);
      chk("tbl_busy",    16'(bus.busy),    16'(tbl[i].busy));
      chk("tbl_tick",    16'(bus.tick),    16'(tbl[i].tick));
      chk("tbl_div_out", 16'(bus.div_out), 16'(tbl[i].dout));
      chk("tbl_div_ack", 16'(bus.div_ack), 16'(tbl[i].ack));
      chk("tbl_div_err", 16'(bus.div_err), 16'(tbl[i].err));
      chk("tbl_cur_div", 16'(bus.cur_div), 16'(tbl[i].cur));
    end

    // N=8 running, load 5 while the counter sits at 2.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    ack_seen = 0;
    step(0, 1, 1, 5);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("seqA_acks", 16'(ack_seen), 16'd1);
    chk("seqA_cur",  16'(bus.cur_div), 16'd5);

    // Zero divisor is rejected without an ack.
    ack_seen = 0;
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("seqB_acks", 16'(ack_seen), 16'd0);
    chk("seqB_cur",  16'(bus.cur_div), 16'd5);

    // Drop run mid-period, drain to idle; then re-raise before TC.
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    chk("seqC_idle", 16'(bus.busy), 16'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    chk("seqC_rerun", 16'(bus.busy), 16'd1);

    // Divide-by-one: tick and div_out every busy cycle.
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    tick_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("seqD_ticks", 16'(tick_seen), 16'd8);
    chk("seqD_dout",  16'(bus.div_out), 16'd1);

    // Two loads in one period: single ack, last value wins; then reset.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    ack_seen = 0;
    step(0, 1, 1, 6);
    step(0, 1, 1, 3);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
    chk("seqE_acks", 16'(ack_seen), 16'd1);
    chk("seqE_cur",  16'(bus.cur_div), 16'd3);
    step(0, 1, 1, 7);
    step(1, 1, 0, 0);
    chk("seqE_rst_cur",  16'(bus.cur_div), 16'd8);
    chk("seqE_rst_busy", 16'(bus.busy), 16'd0);
    step(0, 0, 0, 0);
    chk("seqE_no_ack", 16'(bus.div_ack), 16'd0);

    // Randomized traffic against the model.
    ra = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r, ld;
      int d;
      if ($urandom_range(0, 15) == 0) ra = ~ra;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      step(r, ra, ld, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
